// File: rtl/writeback32.sv
// Purpose: MIPS writeback stage: WB pipeline register, result select and HI/LO registers.
// Latency: one cycle from MEM inputs to Wdata/Waddr/RegWrite. Backpressure: stall holds WB and suppresses RegWrite; flush inserts a bubble.
module writeback32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_Link,
    input  logic        MEM_Mfhi,
    input  logic        MEM_Mflo,
    input  logic        MEM_Mthi,
    input  logic        MEM_Mtlo,
    input  logic        MEM_HiLoWrite,
    input  logic [4:0]  MEM_Waddr,
    input  logic [31:0] MEM_ALU_result,
    input  logic [31:0] MEM_read_data,
    input  logic [31:0] MEM_opcplus4,
    input  logic [31:0] MEM_hi_in,
    input  logic [31:0] MEM_lo_in,
    output logic [31:0] Wdata,
    output logic [4:0]  Waddr,
    output logic        RegWrite,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        WB_valid
);

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
        logic mfhi;
        logic mflo;
        logic mthi;
        logic mtlo;
        logic hilo_write;
    } wb_ctl_t;

    typedef struct packed {
        wb_ctl_t     ctl;
        logic [4:0]  waddr;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] opcplus4;
        logic [31:0] hi_in;
        logic [31:0] lo_in;
    } wb_t;

    wb_t  wb_q;
    wb_t  mem_d;
    logic wb_valid_q;
    logic commit;

    always_comb begin
        mem_d                = '0;
        mem_d.ctl.reg_write  = MEM_RegWrite;
        mem_d.ctl.mem_to_reg = MEM_MemtoReg;
        mem_d.ctl.link       = MEM_Link;
        mem_d.ctl.mfhi       = MEM_Mfhi;
        mem_d.ctl.mflo       = MEM_Mflo;
        mem_d.ctl.mthi       = MEM_Mthi;
        mem_d.ctl.mtlo       = MEM_Mtlo;
        mem_d.ctl.hilo_write = MEM_HiLoWrite;
        mem_d.waddr          = MEM_Waddr;
        mem_d.alu_result     = MEM_ALU_result;
        mem_d.read_data      = MEM_read_data;
        mem_d.opcplus4       = MEM_opcplus4;
        mem_d.hi_in          = MEM_hi_in;
        mem_d.lo_in          = MEM_lo_in;
    end

    // The WB instruction retires at the end of any unstalled cycle, flushed or not.
    assign commit = wb_valid_q && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_q       <= '0;
            wb_valid_q <= 1'b0;
            HI         <= '0;
            LO         <= '0;
        end else begin
            if (commit) begin
                if (wb_q.ctl.hilo_write) begin
                    HI <= wb_q.hi_in;
                    LO <= wb_q.lo_in;
                end else if (wb_q.ctl.mthi) begin
                    HI <= wb_q.alu_result;
                end else if (wb_q.ctl.mtlo) begin
                    LO <= wb_q.alu_result;
                end
            end
            if (flush) begin
                wb_q.ctl   <= '0;
                wb_valid_q <= 1'b0;
            end else if (!stall) begin
                wb_q       <= mem_d;
                wb_valid_q <= 1'b1;
            end
        end
    end

    // Mfhi/Mflo see the registered HI/LO, i.e. the value before this edge's update.
    always_comb begin
        if (wb_q.ctl.link)            Wdata = wb_q.opcplus4;
        else if (wb_q.ctl.mfhi)       Wdata = HI;
        else if (wb_q.ctl.mflo)       Wdata = LO;
        else if (wb_q.ctl.mem_to_reg) Wdata = wb_q.read_data;
        else                          Wdata = wb_q.alu_result;
    end

    assign Waddr    = wb_q.waddr;
    assign RegWrite = wb_q.ctl.reg_write && wb_valid_q && (wb_q.waddr != 5'd0) && !stall;
    assign WB_valid = wb_valid_q;

endmodule
